sq_image_cache_reader: RTL and testbench

SQ_IMAGE_CACHE_READER -- requirements
Module: sq_image_cache_reader

---
 rtl/sq_image_cache_reader_pkg.sv | 28 ++
 rtl/sq_image_cache_reader_if.sv | 13 +
 rtl/sq_image_cache_rd_fifo.sv | 55 +++++
 rtl/sq_image_cache_reader.sv | 151 +++++++++++++++
 tb/tb_sq_image_cache_reader.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sq_image_cache_reader_pkg.sv
// Shared constants, FSM state type and the cache read-request struct for the image cache reader.
package pkg_SQImageCache;

    localparam int WORD_SIZE          = 8;
    localparam int ROW_WIDTH          = 64;
    localparam int COL_WIDTH          = 64;
    localparam int ADDR_WIDTH         = 8;
    localparam int SQIC_RD_FIFO_DEPTH = 2;
    localparam int SQIC_RD_CNT_W      = $clog2(SQIC_RD_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } sqic_rd_state_e;

endpackage

package structs;

    typedef struct packed {
        logic                                   re;
        logic [pkg_SQImageCache::ADDR_WIDTH-1:0] raddrX;
        logic [pkg_SQImageCache::ADDR_WIDTH-1:0] raddrY;
    } struct_SQImageCache_Read;

endpackage

// File: rtl/sq_image_cache_reader_if.sv
// Valid/ready word stream used between the reader and its output FIFO.
interface sq_image_cache_reader_if #(
    parameter int WIDTH = pkg_SQImageCache::WORD_SIZE
) ();

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sq_image_cache_rd_fifo.sv
// Small shift-register FIFO; entry 0 is always the head so the output needs no read mux.
module sq_image_cache_rd_fifo
    import pkg_SQImageCache::*;
#(
    parameter int DATA_WIDTH = WORD_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    sq_image_cache_reader_if.slave    pushS,
    sq_image_cache_reader_if.master   popS,
    output logic [SQIC_RD_CNT_W-1:0]  count_o
);

    localparam int IDX_W = $clog2(SQIC_RD_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]    mem_q [SQIC_RD_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [SQIC_RD_FIFO_DEPTH];
    logic [SQIC_RD_CNT_W-1:0] count_q, count_d;
    logic                     pushFire, popFire;
    logic [IDX_W-1:0]         wrIdx;

    assign pushS.ready = (count_q != SQIC_RD_CNT_W'(SQIC_RD_FIFO_DEPTH));
    assign popS.valid  = (count_q != '0);
    assign popS.data   = mem_q[0];
    assign count_o     = count_q;

    assign pushFire = pushS.valid && pushS.ready;
    assign popFire  = popS.valid && popS.ready;
    // A simultaneous pop shifts the queue down, so the new word lands one slot lower.
    assign wrIdx    = IDX_W'(count_q - SQIC_RD_CNT_W'(popFire));

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q + SQIC_RD_CNT_W'(pushFire) - SQIC_RD_CNT_W'(popFire);
        if (popFire) begin
            for (int i = 0; i < SQIC_RD_FIFO_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (pushFire) begin
            mem_d[wrIdx] = pushS.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/sq_image_cache_reader.sv
// Streams one cached frame out in raster order with a 2-entry FIFO absorbing read latency.
// Optional sof/eol frame markers are built when SQIC_READER_FRAME_MARKERS_EN is defined.
module sq_image_cache_reader
    import pkg_SQImageCache::*;
#(
    parameter int WORD_SIZE  = pkg_SQImageCache::WORD_SIZE,
    parameter int ROW_WIDTH  = pkg_SQImageCache::ROW_WIDTH,
    parameter int COL_WIDTH  = pkg_SQImageCache::COL_WIDTH,
    parameter int ADDR_WIDTH = pkg_SQImageCache::ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           loaded,
    output structs::struct_SQImageCache_Read sqcr,
    input  logic [WORD_SIZE-1:0]           rdata,
    output logic [WORD_SIZE-1:0]           data,
    output logic                           data_ready,
    input  logic                           data_wanted,
    output logic                           busy,
    output logic                           done
`ifdef SQIC_READER_FRAME_MARKERS_EN
    ,
    output logic                           sof,
    output logic                           eol
`endif
);

`ifdef SQIC_READER_FRAME_MARKERS_EN
    localparam int MARK_W = 2;
`else
    localparam int MARK_W = 0;
`endif
    localparam int FIFO_W = WORD_SIZE + MARK_W;
    localparam int OCC_W  = SQIC_RD_CNT_W + 1;

    sqic_rd_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]    x_q, x_d, y_q, y_d;
    logic                     inFlight_q;
    logic [SQIC_RD_CNT_W-1:0] fifoCount;
    logic [OCC_W-1:0]         projected;
    logic                     readEn, popFire, outValid, lastAddr, lastPixel, rowEnd;
    logic [FIFO_W-1:0]        pushWord, outWord;

    sq_image_cache_reader_if #(.WIDTH(FIFO_W)) fifoIn ();
    sq_image_cache_reader_if #(.WIDTH(FIFO_W)) fifoOut ();

    sq_image_cache_rd_fifo #(.DATA_WIDTH(FIFO_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .pushS   (fifoIn.slave),
        .popS    (fifoOut.master),
        .count_o (fifoCount)
    );

`ifdef SQIC_READER_FRAME_MARKERS_EN
    logic sofInFlight_q, eolInFlight_q;
    assign pushWord = {rdata, sofInFlight_q, eolInFlight_q};
    assign sof      = outValid && outWord[1];
    assign eol      = outValid && outWord[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sofInFlight_q <= 1'b0;
            eolInFlight_q <= 1'b0;
        end else begin
            sofInFlight_q <= readEn && (x_q == '0) && (y_q == '0);
            eolInFlight_q <= readEn && rowEnd;
        end
    end
`else
    assign pushWord = rdata;
`endif

    // An empty FIFO lets the in-flight word bypass straight to the output, saving one cycle.
    assign outValid   = fifoOut.valid || inFlight_q;
    assign outWord    = fifoOut.valid ? fifoOut.data : (inFlight_q ? pushWord : '0);
    assign popFire    = outValid && data_wanted;
    assign fifoOut.ready = data_wanted;
    assign fifoIn.valid  = inFlight_q && !(data_wanted && !fifoOut.valid);
    assign fifoIn.data   = pushWord;

    assign data       = outWord[FIFO_W-1 -: WORD_SIZE];
    assign data_ready = outValid;
    assign busy       = (state_q == STREAM) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

    // Words held once this cycle settles; a new read may only go out if it still fits.
    assign projected  = OCC_W'(fifoCount) + OCC_W'(inFlight_q) - OCC_W'(popFire);
    assign readEn     = (state_q == STREAM) && (projected < OCC_W'(SQIC_RD_FIFO_DEPTH));
    assign rowEnd     = (x_q == ADDR_WIDTH'(ROW_WIDTH - 1));
    assign lastAddr   = rowEnd && (y_q == ADDR_WIDTH'(COL_WIDTH - 1));
    assign lastPixel  = (state_q == DRAIN) && popFire && (projected == '0);

    assign sqcr = '{re: readEn, raddrX: x_q, raddrY: y_q};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start && loaded) begin
                    state_d = STREAM;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            STREAM: begin
                if (readEn) begin
                    if (lastAddr) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = DRAIN;
                    end else if (rowEnd) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (lastPixel) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            inFlight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inFlight_q <= readEn;
        end
    end

endmodule

// File: tb/tb_sq_image_cache_reader.sv
// Directed bench for sq_image_cache_reader on a 4x4 frame with a 1-cycle-latency cache model.
// Define SQIC_READER_FRAME_MARKERS_EN to also check the sof/eol markers.
module tb_sq_image_cache_reader;

    localparam int WS = 8;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic loaded;
    logic busy;
    logic done;
    logic [WS-1:0] rdata = '0;
    structs::struct_SQImageCache_Read sqcr;
`ifdef SQIC_READER_FRAME_MARKERS_EN
    logic sof, eol;
`endif

    int checks = 0;
    int errors = 0;
    int maxFifo = 0;

    sq_image_cache_reader_if #(.WIDTH(WS)) pixBus ();

    sq_image_cache_reader #(
        .WORD_SIZE  (WS),
        .ROW_WIDTH  (4),
        .COL_WIDTH  (4),
        .ADDR_WIDTH (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .loaded      (loaded),
        .sqcr        (sqcr),
        .rdata       (rdata),
        .data        (pixBus.data),
        .data_ready  (pixBus.valid),
        .data_wanted (pixBus.ready),
        .busy        (busy),
        .done        (done)
`ifdef SQIC_READER_FRAME_MARKERS_EN
        ,
        .sof         (sof),
        .eol         (eol)
`endif
    );

    always #5 clk = ~clk;

    // Cache model: pixel at (x,y) holds A0 + y*4 + x, returned one cycle after re.
    always @(posedge clk) begin
        if (sqcr.re) begin
            rdata <= 8'(8'hA0 + sqcr.raddrY * 4 + sqcr.raddrX);
        end
    end

    always @(negedge clk) begin
        if (int'(dut.fifoCount) > maxFifo) maxFifo = int'(dut.fifoCount);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic l, input logic w);
        @(posedge clk);
        #1;
        start        = s;
        loaded       = l;
        pixBus.ready = w;
    endtask

    // Runs one frame; abortAt>=0 returns after that many pixels, extraStartAt re-pulses start.
    task automatic runFrame(input logic [3:0] wantPattern, input int abortAt, input int extraStartAt);
        int        collected   = 0;
        int        doneCount   = 0;
        int        doneCyc     = -1;
        int        lastXferCyc = -1;
        logic      prevStall   = 1'b0;
        logic [WS-1:0] prevData = '0;
        bit        fullRate    = (wantPattern == 4'b1111);
        applyStimulus(1'b1, 1'b1, wantPattern[0]);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (prevStall) begin
                checkOutput("stall_hold", 32'(pixBus.data), 32'(prevData));
                checkOutput("stall_ready", 32'(pixBus.valid), 32'd1);
            end
            if (cyc == 1) checkOutput("busy_after_start", 32'(busy), 32'd1);
            if (pixBus.valid && pixBus.ready) begin
                checkOutput("pixel_value", 32'(pixBus.data), 32'(8'(8'hA0 + collected)));
                if (fullRate) checkOutput("pixel_cycle", 32'(cyc), 32'(collected + 2));
`ifdef SQIC_READER_FRAME_MARKERS_EN
                checkOutput("sof", 32'(sof), 32'(collected == 0));
                checkOutput("eol", 32'(eol), 32'(collected % 4 == 3));
`endif
                collected++;
                lastXferCyc = cyc;
            end
            prevStall = pixBus.valid && !pixBus.ready;
            prevData  = pixBus.data;
            if (done) begin
                doneCount++;
                doneCyc = cyc;
                checkOutput("busy_in_done", 32'(busy), 32'd0);
            end
            if (abortAt >= 0 && collected == abortAt) break;
            if (doneCount > 0 && cyc >= doneCyc + 3) break;
            applyStimulus(cyc + 1 == extraStartAt, 1'b1, wantPattern[(cyc + 1) % 4]);
        end
        if (abortAt < 0) begin
            checkOutput("pixel_count", 32'(collected), 32'd16);
            checkOutput("done_pulses", 32'(doneCount), 32'd1);
            checkOutput("done_timing", 32'(doneCyc), 32'(lastXferCyc + 1));
        end
    endtask

    task automatic checkAllZero(input string phase);
        checkOutput({phase, "_re"},    32'(sqcr.re),      32'd0);
        checkOutput({phase, "_ready"}, 32'(pixBus.valid), 32'd0);
        checkOutput({phase, "_busy"},  32'(busy),         32'd0);
        checkOutput({phase, "_done"},  32'(done),         32'd0);
        checkOutput({phase, "_data"},  32'(pixBus.data),  32'd0);
        checkOutput({phase, "_x"},     32'(sqcr.raddrX),  32'd0);
        checkOutput({phase, "_y"},     32'(sqcr.raddrY),  32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        loaded       = 1'b0;
        pixBus.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("post_reset");

        $display("[TB] full-rate 4x4 frame");
        runFrame(4'b1111, -1, -1);

        $display("[TB] backpressure 1,0,0,1");
        maxFifo = 0;
        runFrame(4'b1001, -1, -1);
        checkOutput("fifo_max_le2", 32'(maxFifo <= 2), 32'd1);

        $display("[TB] start while not loaded");
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("noload_re", 32'(sqcr.re), 32'd0);
        checkOutput("noload_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("noload_re2", 32'(sqcr.re), 32'd0);
        checkOutput("noload_busy2", 32'(busy), 32'd0);
        checkOutput("noload_ready", 32'(pixBus.valid), 32'd0);

        $display("[TB] start during stream");
        runFrame(4'b1111, -1, 5);

        $display("[TB] reset at pixel 7");
        runFrame(4'b1111, 8, -1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_no_pixel", 32'(pixBus.valid), 32'd0);
            checkOutput("abort_idle", 32'(busy), 32'd0);
        end
        runFrame(4'b1111, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
